// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the carry-save resolver.
package csa_pkg;

  // Controller states: wait for operands, resolve chunks, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of BUSY cycles needed to resolve a (w+1)-bit sum chunk by chunk.
  function automatic int calc_nch(input int w, input int chunk);
    return (w + 1) / chunk;
  endfunction

  // The result width must split into whole chunks, otherwise the top bits
  // would never be resolved.
  function automatic bit chunking_ok(input int w, input int chunk);
    return (chunk > 0) && (((w + 1) % chunk) == 0);
  endfunction

endpackage

// File: rtl/csa_resolve_seq_if.sv
// Operand/result handshake bundle for csa_resolve_seq.
// The master supplies operands and consumes results; the slave is the resolver.
interface csa_resolve_seq_if #(
  parameter int W = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ps;
  logic [W-1:0] sc;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   q;
  logic         ovf;

  modport master (
    output in_valid, ps, sc, out_ready,
    input  in_ready, out_valid, q, ovf
  );

  modport slave (
    input  in_valid, ps, sc, out_ready,
    output in_ready, out_valid, q, ovf
  );
endinterface

// File: rtl/csa_chunk_add.sv
// CHUNK-bit ripple adder slice with carry in/out. Purely combinational; the
// resolver reuses this one slice on every BUSY cycle.
module csa_chunk_add #(
  parameter int CHUNK = 5
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  // Widen by one bit so the carry out falls out of the addition directly.
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
  end

endmodule

// File: rtl/csa_resolve_seq.sv
// Multi-cycle carry-propagate resolver: q = ps + (sc << 1), computed CHUNK
// bits per cycle with the inter-chunk carry held in a register so the
// critical path is a single CHUNK-bit adder.
module csa_resolve_seq
  import csa_pkg::*;
#(
  parameter int W     = 24,
  parameter int CHUNK = 5
) (
  input  logic                clk,
  input  logic                rst,
  csa_resolve_seq_if.slave    bus,
  output logic                busy
);

  localparam int NCH = calc_nch(W, CHUNK);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

  // Refuse to build with a chunk size that does not tile the result.
  if (!chunking_ok(W, CHUNK)) begin : g_bad_chunk
    $error("csa_resolve_seq: (W+1) must be a multiple of CHUNK");
  end

  state_e          state_q, state_d;
  logic [W:0]      s0_q, s0_d;      // shifted carry vector, consumed LSB first
  logic [W:0]      s1_q, s1_d;      // partial-sum vector, consumed LSB first
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W:0]      q_q, q_d;        // result assembled from the top downward
  logic            ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic [W+CHUNK:0] q_shift;

  logic in_ready_c;
  logic out_valid_c;
  logic busy_c;

  // Lowest unresolved chunk of both vectors plus the carry from the last one.
  csa_chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .a_i    (s0_q[CHUNK-1:0]),
    .b_i    (s1_q[CHUNK-1:0]),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout)
  );

  // New chunk enters at the MSB end; after NCH shifts the first chunk lands
  // at bit 0 and the register holds the full sum in order.
  assign q_shift = {chunk_sum, q_q} >> CHUNK;

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    ovf_d       = ovf_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          // Operands are captured only here; later ps/sc changes are ignored.
          s0_d    = {bus.sc, 1'b0};
          s1_d    = {1'b0, bus.ps};
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        busy_c  = 1'b1;
        q_d     = q_shift[W:0];
        s0_d    = s0_q >> CHUNK;
        s1_d    = s1_q >> CHUNK;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Carry out of the top chunk is the bit beyond the W+1-bit result.
          ovf_d   = chunk_cout;
          state_d = DONE;
        end
      end

      DONE: begin
        // Result is held untouched for as long as the consumer stalls.
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the datapath is reset as well as the FSM so an aborted
      // operation leaves no stale partial sum or carry behind.
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.q         = q_q;
  assign bus.ovf       = ovf_q;
  assign busy          = busy_c;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Self-checking bench for csa_resolve_seq: directed vectors with hand-computed
// sums, backpressure, mid-operation reset and a randomized handshake stream.
module tb_csa_resolve_seq;

  localparam int W     = 24;
  localparam int CHUNK = 5;
  localparam int NCH   = 5;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  csa_resolve_seq_if #(.W(W)) bus ();

  csa_resolve_seq #(
    .W     (W),
    .CHUNK (CHUNK)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [25:0] exp_fifo [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand pair at a negedge in IDLE; returns at the negedge of
  // the first BUSY cycle with the operand bus scrambled.
  task automatic send(input string tag, input logic [W-1:0] p, input logic [W-1:0] s);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.ps       = p;
    bus.sc       = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ps       = ~p;
    bus.sc       = s ^ 24'h5A5A5A;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_busy"}, bus.in_ready, 0);
  endtask

  // Wait (bounded) for out_valid, counting cycles since acceptance.
  task automatic wait_done(input string tag);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, NCH + 1);
  endtask

  // Complete the output handshake and confirm the return to IDLE.
  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_ready"}, bus.in_ready, 1);
    check({tag, "_idle_valid"}, bus.out_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] p, input logic [W-1:0] s,
                        input logic [W:0] exp_q, input logic exp_ovf);
    send(tag, p, s);
    wait_done(tag);
    check({tag, "_q"}, bus.q, exp_q);
    check({tag, "_ovf"}, bus.ovf, exp_ovf);
    release_result(tag);
  endtask

  initial begin
    int          sent;
    int          got;
    int          cyc;
    logic [W-1:0] rp;
    logic [W-1:0] rs;
    logic [25:0]  e;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ps        = '0;
    bus.sc        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_q", bus.q, 0);
    check("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed sums, hand-computed.
    run_op("one_one",  24'h000001, 24'h000001, 25'h0000003, 1'b0);
    run_op("ps_ones",  24'hFFFFFF, 24'h000000, 25'h0FFFFFF, 1'b0);
    run_op("msb_msb",  24'h800000, 24'h800000, 25'h1800000, 1'b0);
    run_op("all_ones", 24'hFFFFFF, 24'hFFFFFF, 25'h0FFFFFD, 1'b1);
    run_op("mixed",    24'h123456, 24'h654321, 25'h0DCBA98, 1'b0);

    // Backpressure: result must hold and stray inputs must be ignored.
    send("bp", 24'h123456, 24'h654321);
    wait_done("bp");
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus.out_valid, 1);
      check("bp_q", bus.q, 25'h0DCBA98);
      check("bp_ovf", bus.ovf, 0);
      check("bp_in_ready", bus.in_ready, 0);
      bus.in_valid = (i % 2 == 1);
      bus.ps       = 24'h000100 + 24'(i);
      bus.sc       = 24'h000077;
      @(negedge clk);
    end
    check("bp_q_end", bus.q, 25'h0DCBA98);
    // Input and output handshake offered together in DONE: only the output
    // side completes, the input is taken in the following IDLE cycle.
    bus.in_valid  = 1'b1;
    bus.ps        = 24'h000004;
    bus.sc        = 24'h000002;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("dual_idle_ready", bus.in_ready, 1);
    check("dual_idle_busy", busy, 0);
    check("dual_idle_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("dual_busy", busy, 1);
    wait_done("dual");
    check("dual_q", bus.q, 25'h0000008);
    check("dual_ovf", bus.ovf, 0);
    release_result("dual");

    // Reset during the third BUSY cycle aborts the operation.
    send("abort", 24'h0FFFFF, 24'h0ABCDE);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy3", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_q", bus.q, 0);
    check("abort_ovf", bus.ovf, 0);
    run_op("after_rst", 24'h000010, 24'h000008, 25'h0000020, 1'b0);

    // Randomized stream against the reference sum ps + 2*sc.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 1000 || exp_fifo.size() != 0) && cyc < 60000) begin
      case ($urandom_range(0, 7))
        0:       rp = 24'hFFFFFF;
        1:       rp = 24'h000000;
        default: rp = 24'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rs = 24'hFFFFFF;
        1:       rs = 24'h000000;
        default: rs = 24'($urandom);
      endcase
      bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.ps        = rp;
      bus.sc        = rs;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) begin
        e = {2'b00, rp} + {1'b0, rs, 1'b0};
        exp_fifo.push_back(e);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_fifo.size() == 0) begin
          check("rand_unexpected", 1, 0);
        end else begin
          e = exp_fifo.pop_front();
          check("rand_result", {bus.ovf, bus.q}, e);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_sent", sent, 1000);
    check("rand_received", got, 1000);
    check("rand_pending", exp_fifo.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
